// File: rtl/phase_detector_seq_mc.sv
// phase_detector_seq_mc: shared round-robin XOR/CPY/LUT/FLT/MUX strobe sequencer.
// Optional periodic auto-trigger is built when PHSEQ_AUTOTRIG_EN is defined.
module phase_detector_seq_mc #(
    parameter int NCH         = 4,
    parameter int CHW         = 2,
    parameter int XOR_LEN     = 1,
    parameter int AUTO_PERIOD = 1024
) (
    input  logic           CLK80,
    input  logic           reset,
    input  logic [NCH-1:0] trig,
    input  logic           auto_en,
    input  logic           clr_ovr,
    output logic           xor_ena,
    output logic           xor_res,
    output logic           store,
    output logic           lut,
    output logic           phcnt,
    output logic           demux,
    output logic [CHW-1:0] ch_sel,
    output logic           busy,
    output logic [NCH-1:0] done,
    output logic           overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XOR  = 3'd1,
        S_CPY  = 3'd2,
        S_LUT  = 3'd3,
        S_FLT  = 3'd4,
        S_MUX  = 3'd5
    } state_t;

    localparam logic [7:0]     XLEN     = 8'(XOR_LEN);
    localparam logic [CHW-1:0] LAST_RST = CHW'(NCH - 1);

    state_t         state;
    state_t         state_d;
    logic [7:0]     cnt;
    logic [7:0]     cnt_d;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] req;
    logic [NCH-1:0] auto_req;
    logic [NCH-1:0] done_d;
    logic [CHW-1:0] last;
    logic [CHW-1:0] win;
    logic           found;
    logic           grant;
    logic           ovr_set;

`ifdef PHSEQ_AUTOTRIG_EN
    localparam logic [15:0] AP_MAX = 16'(AUTO_PERIOD - 1);

    logic [15:0] acnt;

    // Auto-trigger period counter, parked at zero while disabled
    always_ff @(posedge CLK80 or posedge reset) begin
        if (reset) begin
            acnt <= '0;
        end else if (!auto_en) begin
            acnt <= '0;
        end else if (acnt == AP_MAX) begin
            acnt <= '0;
        end else begin
            acnt <= acnt + 16'd1;
        end
    end

    assign auto_req = (auto_en && (acnt == AP_MAX)) ? '1 : '0;
`else
    logic unused_auto;

    assign unused_auto = auto_en | (AUTO_PERIOD == 0);
    assign auto_req    = '0;
`endif

    assign req = pend | trig | auto_req;

    // Round-robin pick, searching from one past the last granted channel
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        win   = last;
        for (int k = 1; k <= NCH; k++) begin
            j = int'(last) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!found && (i == j) && req[i]) begin
                    found = 1'b1;
                    win   = CHW'(i);
                end
            end
        end
    end

    // Next-state logic; XOR dwell is timed by a down-counter loaded on grant
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant   = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_d = S_XOR;
                    cnt_d   = XLEN;
                    grant   = 1'b1;
                end
            end
            S_XOR: begin
                if (cnt <= 8'd1) begin
                    state_d = S_CPY;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            S_CPY:   state_d = S_LUT;
            S_LUT:   state_d = S_FLT;
            S_FLT:   state_d = S_MUX;
            S_MUX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pending-request bookkeeping, overrun detection and done decode
    always_comb begin
        pend_d  = pend;
        done_d  = '0;
        ovr_set = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant && (win == CHW'(i))) begin
                pend_d[i] = pend[i] & trig[i];
            end else begin
                pend_d[i] = pend[i] | trig[i] | auto_req[i];
                if (trig[i] && pend[i]) begin
                    ovr_set = 1'b1;
                end
            end
            done_d[i] = (state == S_MUX) && (ch_sel == CHW'(i));
        end
    end

    // State and XOR dwell counter registers
    always_ff @(posedge CLK80 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Arbitration state, channel select, done pulses and sticky overrun
    always_ff @(posedge CLK80 or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            last    <= LAST_RST;
            ch_sel  <= '0;
            done    <= '0;
            overrun <= 1'b0;
        end else begin
            pend <= pend_d;
            if (grant) begin
                ch_sel <= win;
                last   <= win;
            end
            done    <= done_d;
            overrun <= ovr_set | (overrun & ~clr_ovr);
        end
    end

    // Strobes registered from the next state so they align with the state
    always_ff @(posedge CLK80 or posedge reset) begin
        if (reset) begin
            xor_ena <= 1'b1;
            store   <= 1'b0;
            xor_res <= 1'b0;
            lut     <= 1'b0;
            phcnt   <= 1'b0;
            demux   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            xor_ena <= (state_d == S_IDLE) || (state_d == S_FLT) ||
                       (state_d == S_MUX);
            store   <= (state_d == S_XOR);
            xor_res <= (state_d == S_CPY);
            lut     <= (state_d == S_LUT);
            phcnt   <= (state_d == S_FLT);
            demux   <= (state_d == S_MUX);
            busy    <= (state_d != S_IDLE);
        end
    end

endmodule
